// File: rtl/recursion_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : recursion_ctrl_if
//  Description : Bundle of the host request/response signals and the external
//                stack command/data signals of recursion_ctrl.
//                master : host + stack side (drives start, n, stk_dout, stk_empty)
//                slave  : recursion_ctrl side (drives busy, done, result, err,
//                         stk_push, stk_top, stk_pop, stk_din[, cycles])
//                Optional macro RECURSION_CYCLE_CNT_EN adds cycles[15:0].
//  Revision    : 1.0 - initial release
// ============================================================================
interface recursion_ctrl_if;
    logic        start;
    logic [4:0]  n;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        err;
    logic        stk_push;
    logic        stk_top;
    logic        stk_pop;
    logic [10:0] stk_din;
    logic [10:0] stk_dout;
    logic        stk_empty;
`ifdef RECURSION_CYCLE_CNT_EN
    logic [15:0] cycles;
`endif

    modport master (
        output start, n, stk_dout, stk_empty,
        input  busy, done, result, err, stk_push, stk_top, stk_pop, stk_din
`ifdef RECURSION_CYCLE_CNT_EN
        , input cycles
`endif
    );

    modport slave (
        input  start, n, stk_dout, stk_empty,
        output busy, done, result, err, stk_push, stk_top, stk_pop, stk_din
`ifdef RECURSION_CYCLE_CNT_EN
        , output cycles
`endif
    );
endinterface
`default_nettype wire

// File: rtl/recursion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : recursion_ctrl
//  Description : Computes fib(n) for n <= 20 by tree recursion on an external
//                32-entry stack. Each popped value x is either a leaf (x < 2,
//                added to the accumulator) or is replaced by x-1 and x-2.
//                n > 20 is rejected with err and issues no stack command.
//  Ports       : clk, rst (sync, active high)
//                bus (recursion_ctrl_if.slave):
//                  start, n        - request, accepted only in IDLE
//                  busy, done      - status / one-cycle completion pulse
//                  result, err     - held from done until next accepted start
//                  stk_push/top/pop, stk_din, stk_dout, stk_empty - stack
//  Config      : `define RECURSION_CYCLE_CNT_EN adds cycles[15:0], the
//                saturating start-to-done cycle count.
//  Revision    : 1.0 - initial release
// ============================================================================
module recursion_ctrl (
    input  wire logic         clk,
    input  wire logic         rst,
    recursion_ctrl_if.slave   bus
);

    typedef enum logic [3:0] {
        S_FLUSH  = 4'd0,
        S_IDLE   = 4'd1,
        S_PUSH_N = 4'd2,
        S_CHECK  = 4'd3,
        S_POP    = 4'd4,
        S_EVAL   = 4'd5,
        S_PUSH_A = 4'd6,
        S_PUSH_B = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    localparam logic [4:0] c_N_MAX = 5'd20;

    state_t      r_state;
    logic [4:0]  r_x;
    logic [15:0] r_acc;
    logic [15:0] r_result;
    logic        r_err;
    logic        r_bad;
    logic        r_done;
    logic        r_push;
    logic        r_pop;
    logic [4:0]  r_din;

    logic [4:0]  w_x;
    logic        w_flush_pop;
    logic        w_unused_dout;

    assign w_x           = bus.stk_dout[4:0];
    assign w_unused_dout = ^bus.stk_dout[10:5];

    // Stack commands are registered on entry to the state that issues them,
    // so they are high for exactly the cycle spent in PUSH_N/POP/PUSH_A/PUSH_B.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FLUSH;
            r_x      <= 5'd0;
            r_acc    <= 16'd0;
            r_result <= 16'd0;
            r_err    <= 1'b0;
            r_bad    <= 1'b0;
            r_done   <= 1'b0;
            r_push   <= 1'b0;
            r_pop    <= 1'b0;
            r_din    <= 5'd0;
        end else begin
            r_push <= 1'b0;
            r_pop  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_FLUSH: begin
                    if (bus.stk_empty) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (bus.start) begin
                        r_acc <= 16'd0;
                        if (bus.n > c_N_MAX) begin
                            // Out-of-range requests take one pass through
                            // CHECK, which completes immediately for them, so
                            // done lands two cycles after start with no stack
                            // traffic.
                            r_bad   <= 1'b1;
                            r_state <= S_CHECK;
                        end else begin
                            r_bad   <= 1'b0;
                            r_push  <= 1'b1;
                            r_din   <= bus.n;
                            r_state <= S_PUSH_N;
                        end
                    end
                end
                S_PUSH_N: begin
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (r_bad || bus.stk_empty) begin
                        r_done   <= 1'b1;
                        r_err    <= r_bad;
                        r_result <= r_bad ? 16'd0 : r_acc;
                        r_state  <= S_DONE;
                    end else begin
                        r_pop   <= 1'b1;
                        r_state <= S_POP;
                    end
                end
                S_POP: begin
                    // The stack registers its read data on this edge.
                    r_state <= S_EVAL;
                end
                S_EVAL: begin
                    r_x <= w_x;
                    if (w_x < 5'd2) begin
                        r_acc   <= r_acc + {11'd0, w_x};
                        r_state <= S_CHECK;
                    end else begin
                        r_push  <= 1'b1;
                        r_din   <= w_x - 5'd1;
                        r_state <= S_PUSH_A;
                    end
                end
                S_PUSH_A: begin
                    r_push  <= 1'b1;
                    r_din   <= r_x - 5'd2;
                    r_state <= S_PUSH_B;
                end
                S_PUSH_B: begin
                    r_state <= S_CHECK;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_FLUSH;
                end
            endcase
        end
    end

    // The stack keeps its contents through reset, so FLUSH drains it one entry
    // per cycle. This pop must follow stk_empty combinationally: a registered
    // version would issue one pop too many on the last entry.
    assign w_flush_pop = (r_state == S_FLUSH) && !bus.stk_empty;

    // Commands are forced low while rst is held so a reset never disturbs the
    // stack contents mid-cycle.
    assign bus.stk_push = r_push & ~rst;
    assign bus.stk_pop  = (r_pop | w_flush_pop) & ~rst;
    assign bus.stk_top  = 1'b0;
    assign bus.stk_din  = {6'b0, r_din};
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.err      = r_err;

`ifdef RECURSION_CYCLE_CNT_EN
    logic [15:0] r_cycles;

    // Cleared by the accepted start, then counts every cycle from PUSH_N (or
    // CHECK) through DONE; reads as the start-to-done span once back in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycles <= 16'd0;
        end else if (r_state == S_IDLE) begin
            if (bus.start) begin
                r_cycles <= 16'd0;
            end
        end else if ((r_state != S_FLUSH) && (r_cycles != 16'hFFFF)) begin
            r_cycles <= r_cycles + 16'd1;
        end
    end

    assign bus.cycles = r_cycles;
`endif

endmodule
`default_nettype wire

// File: doc/recursion_ctrl.md
RECURSION_CTRL -- requirements
Module: recursion_ctrl

Interface
REQ-001 SHALL expose: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL expose: rst  input  1  synchronous active-high reset.
REQ-003 SHALL expose: start  input  1  request to compute fib(n), sampled only in IDLE.
REQ-004 SHALL expose: n  input  5  argument, captured on accepted start.
REQ-005 SHALL expose: busy  output  1  high in every state except IDLE.
REQ-006 SHALL expose: done  output  1  one-cycle pulse when result/err are valid.
REQ-007 SHALL expose: result  output  16  fib(n), held from done until the next accepted start.
REQ-008 SHALL expose: err  output  1  n>20 flag, valid with done, held like result.
REQ-009 SHALL expose: stk_push, stk_top, stk_pop  output  1 each  stack commands, at most one high per cycle; stk_top is always 0.
REQ-010 SHALL expose: stk_din  output  11  push data {6'b0, value}.
REQ-011 SHALL expose: stk_dout  input  11  stack read data, registered by the stack one edge after stk_pop.
REQ-012 SHALL expose: stk_empty  input  1  combinational stack-empty flag.

Function
REQ-013 SHALL implement the states FLUSH, IDLE, PUSH_N, CHECK, POP, EVAL, PUSH_A, PUSH_B, DONE.
REQ-014 IDLE: when start=1, SHALL capture n and clear acc; if n>20 go to DONE with err=1, else go to PUSH_N.
REQ-015 PUSH_N SHALL assert stk_push with stk_din=n, then go to CHECK.
REQ-016 CHECK SHALL go to DONE if stk_empty=1, else to POP.
REQ-017 POP SHALL assert stk_pop, then go to EVAL.
REQ-018 EVAL SHALL latch x=stk_dout[4:0]; if x<2 then acc=acc+x and go to CHECK, else go to PUSH_A.
REQ-019 PUSH_A SHALL push x-1; PUSH_B SHALL then push x-2; next state CHECK.
REQ-020 DONE SHALL pulse done for one cycle, drive result=acc (0 when err=1), then return to IDLE.
REQ-021 acc SHALL be 16 bits; fib(20)=6765 SHALL never overflow it.
REQ-022 Peak stack occupancy SHALL be at most n+1 (at most 21 for n<=20), within the 32-entry stack.
REQ-023 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-024 An err request SHALL issue no stack command.
REQ-025 Latency from the start cycle to done: n=0 or n=1 in 6 cycles; n>20 in 2 cycles.

Reset
REQ-026 On rst=1: state=FLUSH, done=0, result=0, err=0, acc=0, and all stack command outputs 0.
REQ-027 The stack has no reset, so FLUSH SHALL assert stk_pop every cycle while stk_empty=0, then go to IDLE when stk_empty=1.
REQ-028 rst mid-operation SHALL abort the computation without a done pulse; residual stack entries SHALL drain in FLUSH.
REQ-029 busy SHALL be 1 during FLUSH, and start SHALL be ignored during FLUSH.

Configuration
REQ-030 With macro RECURSION_CYCLE_CNT_EN defined, the block SHALL add output cycles [15:0].
REQ-031 cycles SHALL clear on accepted start, count every cycle up to and including the DONE cycle, saturate at 0xFFFF, hold until the next accepted start, and reset to 0.
REQ-032 With RECURSION_CYCLE_CNT_EN undefined, the port and counter SHALL be absent, with function otherwise identical.

Verification
REQ-033 After reset with an empty stack, then start with n=0: done arrives 6 cycles after start, result=0, err=0, and stk_empty=1 afterwards.
REQ-034 start with n=10: result=55, err=0, stack empty at done, and the number of push cycles equals the number of pop cycles.
REQ-035 start with n=20: result=6765, stack occupancy never exceeds 21, and no overflow occurs.
REQ-036 start with n=25: done arrives 2 cycles later, err=1, result=0, and zero stack commands are issued.
REQ-037 Assert rst during n=15 with 5 entries stacked: exactly 5 pop cycles occur in FLUSH, then IDLE; a following n=6 gives result=8.
REQ-038 Pulse start again during an n=12 run: it is ignored, result=144, and with RECURSION_CYCLE_CNT_EN defined, cycles equals the measured start-to-done span.
